// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receiver: deframer states, parity modes
// and the bit-counter width function.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4,
    BRK   = 3'd5
  } rx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int cnt_width(input int div);
    return (div > 2) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Synchronous FIFO with registered first-word-fall-through head; pointers carry
// one extra wrap bit so full and empty are told apart by the MSB.
module uart_rx_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r, rd_ptr_r, wr_nxt_s, rd_nxt_s, level_r;
  logic [WIDTH-1:0] data_r;
  logic             valid_r, empty_s, full_s, push_s, pop_s;

  assign empty_s  = (wr_ptr_r == rd_ptr_r);
  assign full_s   = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_s    = rd_en && valid_r;
  assign push_s   = wr_en && (!full_s || pop_s);
  assign wr_nxt_s = wr_ptr_r + {{AW{1'b0}}, push_s};
  assign rd_nxt_s = rd_ptr_r + {{AW{1'b0}}, pop_s};

  assign rd_data  = data_r;
  assign rd_valid = valid_r;
  assign full     = full_s;
  assign level    = level_r;

  // Storage array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
    end else if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end else begin
      mem_r[wr_ptr_r[AW-1:0]] <= mem_r[wr_ptr_r[AW-1:0]];
    end
  end

  // Pointers and registered head; a word written into an otherwise empty FIFO bypasses the array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      level_r  <= {(AW+1){1'b0}};
      valid_r  <= 1'b0;
      data_r   <= {WIDTH{1'b0}};
    end else begin
      wr_ptr_r <= wr_nxt_s;
      rd_ptr_r <= rd_nxt_s;
      level_r  <= wr_nxt_s - rd_nxt_s;
      valid_r  <= (wr_nxt_s != rd_nxt_s);
      data_r   <= (push_s && (rd_nxt_s == wr_ptr_r)) ? wr_data : mem_r[rd_nxt_s[AW-1:0]];
    end
  end

  logic unused_empty_s;
  assign unused_empty_s = empty_s;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver: input synchroniser, start/data/parity/stop deframer and a receive FIFO.
// Optional break detection is built when UART_RX_BREAK_DET_EN is defined.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int DIV         = 50,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          cpu_clock,
  input  logic                          cpu_rst,
  input  logic                          rx_line,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
`ifdef UART_RX_BREAK_DET_EN
  ,
  output logic                          break_det
`endif
);

  localparam int CW = cnt_width(DIV);
  localparam int WW = DATA_BITS + 2;
`ifdef UART_RX_BREAK_DET_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  logic [1:0]             rst_sync_r;
  logic                   rst_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   rx_s;
  rx_state_e              state_r, state_nxt_s;
  logic [CW-1:0]          cnt_r;
  logic [3:0]             bit_r;
  logic [DATA_BITS-1:0]   shift_r;
  logic                   par_err_r, par_bit_r, busy_r, ovf_r;
  logic                   samp_s, last_bit_s, brk_s, push_s, full_s;
  logic [WW-1:0]          head_s;

  function automatic logic par_bad(input logic [DATA_BITS-1:0] d, input logic p);
    return (^d ^ p) != (PARITY == PAR_ODD);
  endfunction

  // Reset asserts immediately and releases on a clock edge.
  always_ff @(posedge cpu_clock or posedge cpu_rst) begin
    if (cpu_rst) rst_sync_r <= 2'b11;
    else         rst_sync_r <= {rst_sync_r[0], 1'b0};
  end
  assign rst_s = rst_sync_r[1];

  always_ff @(posedge cpu_clock or posedge rst_s) begin
    if (rst_s) sync_r <= {SYNC_STAGES{1'b1}};
    else       sync_r <= {sync_r[SYNC_STAGES-2:0], rx_line};
  end
  assign rx_s = sync_r[SYNC_STAGES-1];

  assign samp_s     = (state_r == START) ? (cnt_r == CW'((DIV - 1) / 2)) : (cnt_r == CW'(DIV - 1));
  assign last_bit_s = (bit_r == 4'(DATA_BITS - 1));
  assign brk_s      = BRK_EN && (shift_r == {DATA_BITS{1'b0}}) && !par_bit_r && !rx_s;

  always_ff @(posedge cpu_clock or posedge rst_s) begin
    if (rst_s) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:  if (!rx_s) state_nxt_s = START; else state_nxt_s = IDLE;
      START: if (samp_s) state_nxt_s = rx_s ? IDLE : DATA; else state_nxt_s = START;
      DATA:  if (samp_s && last_bit_s) state_nxt_s = (PARITY != PAR_NONE) ? PAR : STOP;
             else state_nxt_s = DATA;
      PAR:   if (samp_s) state_nxt_s = STOP; else state_nxt_s = PAR;
      STOP:  if (samp_s) state_nxt_s = brk_s ? BRK : IDLE; else state_nxt_s = STOP;
      BRK:   if (rx_s) state_nxt_s = IDLE; else state_nxt_s = BRK;
      default: state_nxt_s = IDLE;
    endcase
  end

  always_comb begin
    push_s = 1'b0;
    if (state_r == STOP && samp_s) push_s = !brk_s;
    else                           push_s = 1'b0;
  end

  // Bit timing and data capture; the counter restarts at every sample point.
  always_ff @(posedge cpu_clock or posedge rst_s) begin
    if (rst_s) begin
      cnt_r     <= {CW{1'b0}};
      bit_r     <= 4'd0;
      shift_r   <= {DATA_BITS{1'b0}};
      par_err_r <= 1'b0;
      par_bit_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r     <= {CW{1'b0}};
          bit_r     <= 4'd0;
          par_err_r <= 1'b0;
          par_bit_r <= 1'b0;
        end
        DATA: begin
          cnt_r <= samp_s ? {CW{1'b0}} : cnt_r + 1'b1;
          if (samp_s) begin
            shift_r <= {rx_s, shift_r[DATA_BITS-1:1]};
            bit_r   <= bit_r + 4'd1;
          end
        end
        PAR: begin
          cnt_r <= samp_s ? {CW{1'b0}} : cnt_r + 1'b1;
          if (samp_s) begin
            par_bit_r <= rx_s;
            par_err_r <= par_bad(shift_r, rx_s);
          end
        end
        START, STOP: cnt_r <= samp_s ? {CW{1'b0}} : cnt_r + 1'b1;
        default: cnt_r <= {CW{1'b0}};
      endcase
    end
  end

  // Status flags; a new overflow wins over a simultaneous clear.
  always_ff @(posedge cpu_clock or posedge rst_s) begin
    if (rst_s) begin
      busy_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != IDLE);
      if (push_s && full_s && !(rx_valid && rx_ready)) ovf_r <= 1'b1;
      else if (overflow_clr)                          ovf_r <= 1'b0;
      else                                            ovf_r <= ovf_r;
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  logic break_det_r;
  always_ff @(posedge cpu_clock or posedge rst_s) begin
    if (rst_s) break_det_r <= 1'b0;
    else       break_det_r <= (state_r == STOP) && samp_s && brk_s;
  end
  assign break_det = break_det_r;
`endif

  uart_rx_sync_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (cpu_clock),
    .rst      (rst_s),
    .wr_en    (push_s),
    .wr_data  ({shift_r, !rx_s, par_err_r}),
    .rd_en    (rx_ready),
    .rd_data  (head_s),
    .rd_valid (rx_valid),
    .full     (full_s),
    .level    (fifo_level)
  );

  assign rx_data       = head_s[WW-1:2];
  assign rx_frame_err  = head_s[1];
  assign rx_parity_err = head_s[0];
  assign overflow      = ovf_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: an 8N1 instance and an 8E1 instance, both DIV=8, depth 4.
module tb_uart_rx_fifo;

  logic clk = 1'b0;
  logic cpu_rst = 1'b0;
  logic line_a = 1'b1, line_b = 1'b1;
  logic rdy_a = 1'b0, rdy_b = 1'b0, clr_a = 1'b0, clr_b = 1'b0;
  logic [7:0] data_a, data_b;
  logic fe_a, fe_b, pe_a, pe_b, val_a, val_b, ovf_a, ovf_b, busy_a, busy_b;
  logic [2:0] lvl_a, lvl_b;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

`ifdef UART_RX_BREAK_DET_EN
  logic brk_a, brk_b;
  int brk_cnt_a = 0;
  always @(posedge clk) if (brk_a) brk_cnt_a <= brk_cnt_a + 1;
`endif

  uart_rx_fifo #(.DIV(8), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut_a (
    .cpu_clock(clk), .cpu_rst(cpu_rst), .rx_line(line_a), .rx_data(data_a),
    .rx_frame_err(fe_a), .rx_parity_err(pe_a), .rx_valid(val_a), .rx_ready(rdy_a),
    .overflow(ovf_a), .overflow_clr(clr_a), .fifo_level(lvl_a), .busy(busy_a)
`ifdef UART_RX_BREAK_DET_EN
    , .break_det(brk_a)
`endif
  );

  uart_rx_fifo #(.DIV(8), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut_b (
    .cpu_clock(clk), .cpu_rst(cpu_rst), .rx_line(line_b), .rx_data(data_b),
    .rx_frame_err(fe_b), .rx_parity_err(pe_b), .rx_valid(val_b), .rx_ready(rdy_b),
    .overflow(ovf_b), .overflow_clr(clr_b), .fifo_level(lvl_b), .busy(busy_b)
`ifdef UART_RX_BREAK_DET_EN
    , .break_det(brk_b)
`endif
  );

  typedef struct {
    int         which;
    logic [7:0] d;
    logic       has_par;
    logic       pbit;
    logic       sbit;
    logic [7:0] exp_d;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int which, input logic v);
    if (which == 0) line_a = v;
    else            line_b = v;
  endtask

  // Call right after a negedge; each bit lasts 8 clocks, line is left idle high.
  task automatic send(input int which, input logic [7:0] d, input logic has_par,
                      input logic pbit, input logic sbit);
    logic [10:0] bits;
    int n;
    bits = {sbit, (has_par ? pbit : sbit), d, 1'b0};
    n = has_par ? 11 : 10;
    for (int i = 0; i < n; i++) begin
      drive(which, bits[i]);
      repeat (8) @(negedge clk);
    end
    drive(which, 1'b1);
  endtask

  task automatic pop(input int which);
    if (which == 0) rdy_a = 1'b1; else rdy_b = 1'b1;
    @(negedge clk);
    rdy_a = 1'b0;
    rdy_b = 1'b0;
  endtask

  initial begin
    vecs[0] = '{0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
    vecs[1] = '{0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{0, 8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[3] = '{0, 8'h81, 1'b0, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0};
    vecs[4] = '{1, 8'h07, 1'b1, 1'b0, 1'b1, 8'h07, 1'b0, 1'b1};
    vecs[5] = '{1, 8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    vecs[6] = '{1, 8'h03, 1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
    vecs[7] = '{1, 8'hF1, 1'b1, 1'b0, 1'b0, 8'hF1, 1'b1, 1'b1};

    #2 cpu_rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_valid", 32'(val_a), 32'd0);
    chk("rst_data", 32'(data_a), 32'd0);
    chk("rst_flags", 32'({fe_a, pe_a, ovf_a}), 32'd0);
    chk("rst_level_busy", 32'({lvl_a, busy_a}), 32'd0);
    cpu_rst = 1'b0;
    repeat (6) @(negedge clk);

    // First-word timing: stop sample lands on the 79th rising edge after the start bit.
    fork
      send(0, 8'hA5, 1'b0, 1'b0, 1'b1);
      begin
        repeat (78) @(posedge clk);
        @(negedge clk);
        chk("valid_before_push", 32'(val_a), 32'd0);
        @(negedge clk);
        chk("valid_after_push", 32'(val_a), 32'd1);
      end
    join
    repeat (12) @(negedge clk);
    chk("a5_data", 32'(data_a), 32'hA5);
    chk("a5_flags", 32'({fe_a, pe_a}), 32'd0);
    chk("a5_level", 32'(lvl_a), 32'd1);
    pop(0);
    @(negedge clk);
    chk("a5_pop_valid", 32'(val_a), 32'd0);

    for (int i = 0; i < 8; i++) begin
      logic [7:0] d;
      logic fe, pe, v;
      logic [2:0] l;
      send(vecs[i].which, vecs[i].d, vecs[i].has_par, vecs[i].pbit, vecs[i].sbit);
      repeat (12) @(negedge clk);
      if (vecs[i].which == 0) begin d = data_a; fe = fe_a; pe = pe_a; v = val_a; l = lvl_a; end
      else                    begin d = data_b; fe = fe_b; pe = pe_b; v = val_b; l = lvl_b; end
      chk($sformatf("vec%0d_valid", i), 32'(v), 32'd1);
      chk($sformatf("vec%0d_data", i), 32'(d), 32'(vecs[i].exp_d));
      chk($sformatf("vec%0d_frame_err", i), 32'(fe), 32'(vecs[i].exp_fe));
      chk($sformatf("vec%0d_parity_err", i), 32'(pe), 32'(vecs[i].exp_pe));
      chk($sformatf("vec%0d_level", i), 32'(l), 32'd1);
      pop(vecs[i].which);
      @(negedge clk);
    end

    // Break frame: all-zero data and stop.
`ifdef UART_RX_BREAK_DET_EN
    line_a = 1'b0;
    repeat (96) @(negedge clk);
    chk("brk_busy_held", 32'(busy_a), 32'd1);
    chk("brk_pulse_count", 32'(brk_cnt_a), 32'd1);
    chk("brk_level", 32'(lvl_a), 32'd0);
    line_a = 1'b1;
    repeat (12) @(negedge clk);
    chk("brk_busy_released", 32'(busy_a), 32'd0);
    chk("brk_level_after", 32'(lvl_a), 32'd0);
`else
    send(0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (12) @(negedge clk);
    chk("brk_level", 32'(lvl_a), 32'd1);
    chk("brk_word", 32'({data_a, fe_a}), 32'h001);
    pop(0);
    @(negedge clk);
`endif

    // Two-cycle glitch is a false start.
    line_a = 1'b0;
    repeat (2) @(negedge clk);
    line_a = 1'b1;
    @(negedge clk);
    chk("glitch_busy_start", 32'(busy_a), 32'd1);
    repeat (20) @(negedge clk);
    chk("glitch_idle", 32'({busy_a, val_a}), 32'd0);
    chk("glitch_level", 32'(lvl_a), 32'd0);

    // Fill, then push and pop in the same cycle while full.
    for (int i = 1; i <= 4; i++) begin
      send(0, 8'(i), 1'b0, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
    end
    chk("full_level", 32'(lvl_a), 32'd4);
    fork
      send(0, 8'h05, 1'b0, 1'b0, 1'b1);
      begin
        repeat (78) @(posedge clk);
        @(negedge clk);
        rdy_a = 1'b1;
        @(negedge clk);
        rdy_a = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    chk("pushpop_level", 32'(lvl_a), 32'd4);
    chk("pushpop_no_ovf", 32'(ovf_a), 32'd0);
    chk("pushpop_head", 32'(data_a), 32'h02);
    send(0, 8'h06, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    chk("drop_level", 32'(lvl_a), 32'd4);
    chk("drop_ovf", 32'(ovf_a), 32'd1);
    for (int i = 2; i <= 5; i++) begin
      chk($sformatf("drain_%0d", i), 32'(data_a), 32'(i));
      pop(0);
    end
    chk("drain_empty", 32'({val_a, lvl_a}), 32'd0);
    chk("ovf_sticky", 32'(ovf_a), 32'd1);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    chk("ovf_cleared", 32'(ovf_a), 32'd0);

    // Reset in the middle of 0x55 with a word already queued.
    send(0, 8'h11, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    line_a = 1'b0;
    repeat (8) @(negedge clk);
    line_a = 1'b1;
    repeat (8) @(negedge clk);
    line_a = 1'b0;
    repeat (8) @(negedge clk);
    cpu_rst = 1'b1;
    @(negedge clk);
    chk("midrst_outputs", 32'({val_a, fe_a, pe_a, ovf_a, busy_a}), 32'd0);
    chk("midrst_data_level", 32'({data_a, lvl_a}), 32'd0);
    line_a = 1'b1;
    repeat (3) @(negedge clk);
    cpu_rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("postrst_idle", 32'({busy_a, val_a}), 32'd0);
    send(0, 8'h66, 1'b0, 1'b0, 1'b1);
    repeat (12) @(negedge clk);
    chk("postrst_level", 32'(lvl_a), 32'd1);
    chk("postrst_data", 32'({data_a, fe_a, pe_a}), 32'({8'h66, 2'b00}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
